// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative restoring divider.
// Signedness is selected by the DIV_SIGNED_EN macro in the top module.
package div_pkg;

   localparam int unsigned DIV_W = 16;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

   localparam int unsigned DIV_CNT_W = cnt_width(DIV_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
// The partial remainder a is WIDTH+1 bits, and the sign of the trial subtract selects restore.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   a_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH:0] a_sh;
   logic [WIDTH:0] t;

   always_comb begin
      // The top bit of a drops out of the shifted {A,Q} pair.
      a_sh = (WIDTH+1)'({a, q[WIDTH-1]});
      t    = a_sh - {1'b0, d};
      if (!t[WIDTH]) begin
         a_nxt = t;
         q_nxt = {q[WIDTH-2:0], 1'b1};
      end else begin
         a_nxt = a_sh;
         q_nxt = {q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/restoring_divider.sv
// Iterative restoring divider returning {remainder, quotient} with a fixed WIDTH+2 cycle latency.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module restoring_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 parser_done,
   input  logic [WIDTH-1:0]     src1,
   input  logic [WIDTH-1:0]     src2,
   output logic [2*WIDTH-1:0]   calc_res,
   output logic                 div_done,
   output logic                 div_by_zero,
   output logic                 div_ovf
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   div_state_e       state;
   div_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   acc_nxt;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] quo_nxt;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] dividend;
   logic             zero_q;

   logic             start_c;
   logic             step_c;
   logic             fix_c;
   logic             last_c;
   logic [WIDTH-1:0] mag1_c;
   logic [WIDTH-1:0] mag2_c;
   logic [WIDTH-1:0] q_fix_c;
   logic [WIDTH-1:0] r_fix_c;

`ifdef DIV_SIGNED_EN
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic neg1;
   logic neg2;
   logic ovf_q;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .a     (acc),
      .q     (quo),
      .d     (dvs),
      .a_nxt (acc_nxt),
      .q_nxt (quo_nxt)
   );

   assign last_c = (cnt == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (parser_done) state_nxt = CALC;
         CALC:    if (last_c)      state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control strobes decoded from state
   always_comb begin
      start_c = 1'b0;
      step_c  = 1'b0;
      fix_c   = 1'b0;
      case (state)
         IDLE:    start_c = parser_done;
         CALC:    step_c  = 1'b1;
         FIX:     fix_c   = 1'b1;
         default: ;
      endcase
   end

   // Operand magnitudes and sign fix-up of the raw result
   always_comb begin
`ifdef DIV_SIGNED_EN
      mag1_c  = src1[WIDTH-1] ? (~src1 + WIDTH'(1)) : src1;
      mag2_c  = src2[WIDTH-1] ? (~src2 + WIDTH'(1)) : src2;
      q_fix_c = (neg1 ^ neg2) ? (~quo + WIDTH'(1)) : quo;
      r_fix_c = neg1 ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
`else
      mag1_c  = src1;
      mag2_c  = src2;
      q_fix_c = quo;
      r_fix_c = acc[WIDTH-1:0];
`endif
      if (zero_q) begin
         q_fix_c = '1;
         r_fix_c = dividend;
      end
   end

   // Datapath, counter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         acc         <= '0;
         quo         <= '0;
         dvs         <= '0;
         dividend    <= '0;
         zero_q      <= 1'b0;
         calc_res    <= '0;
         div_done    <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg1        <= 1'b0;
         neg2        <= 1'b0;
         ovf_q       <= 1'b0;
         div_ovf     <= 1'b0;
`endif
      end else begin
         div_done <= fix_c;
         if (start_c) begin
            cnt      <= '0;
            acc      <= '0;
            quo      <= mag1_c;
            dvs      <= mag2_c;
            dividend <= src1;
            zero_q   <= (src2 == '0);
`ifdef DIV_SIGNED_EN
            neg1     <= src1[WIDTH-1];
            neg2     <= src2[WIDTH-1];
            ovf_q    <= (src1 == MIN_VAL) && (src2 == '1);
`endif
         end else if (step_c) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_nxt;
            quo <= quo_nxt;
         end
         if (fix_c) begin
            calc_res    <= {r_fix_c, q_fix_c};
            div_by_zero <= zero_q;
`ifdef DIV_SIGNED_EN
            div_ovf     <= ovf_q;
`endif
         end
      end
   end

`ifndef DIV_SIGNED_EN
   assign div_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (DIV_SIGNED_EN selects signed vectors).
`timescale 1ns/1ps
module tb_restoring_divider;
   import div_pkg::*;

   logic              clk;
   logic              rst;
   logic              parser_done;
   logic [DIV_W-1:0]  src1;
   logic [DIV_W-1:0]  src2;
   logic [2*DIV_W-1:0] calc_res;
   logic              div_done;
   logic              div_by_zero;
   logic              div_ovf;

   int tests;
   int fails;

   restoring_divider #(.WIDTH(DIV_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .parser_done (parser_done),
      .src1        (src1),
      .src2        (src2),
      .calc_res    (calc_res),
      .div_done    (div_done),
      .div_by_zero (div_by_zero),
      .div_ovf     (div_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Start an op, optionally pulse parser_done in given cycles, check result and timing.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_res, input logic exp_dbz, input logic exp_ovf,
                         input logic [31:0] prev_res, input int p0, input int p1, input int p2);
      int lat;
      int ndone;
      lat   = 0;
      ndone = 0;
      src1        = a;
      src2        = b;
      parser_done = 1'b1;
      @(posedge clk);
      #1;
      parser_done = 1'b0;
      src1        = 16'h0005;
      src2        = 16'h0001;
      for (int i = 1; i <= 30; i++) begin
         if (i == p0 || i == p1 || i == p2) parser_done = 1'b1;
         @(posedge clk);
         #1;
         parser_done = 1'b0;
         if (i == 5) check({tag, "_hold"}, calc_res, prev_res);
         if (div_done === 1'b1) begin
            ndone++;
            if (lat == 0) begin
               lat = i + 1;
               check({tag, "_res"}, calc_res, exp_res);
               check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
               check({tag, "_ovf"}, 32'(div_ovf), 32'(exp_ovf));
            end
         end
      end
      check({tag, "_lat"}, 32'(lat), 32'd18);
      check({tag, "_ndone"}, 32'(ndone), 32'd1);
   endtask

   initial begin
      int nd;
      tests       = 0;
      fails       = 0;
      rst         = 1'b1;
      parser_done = 1'b0;
      src1        = '0;
      src2        = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_res", calc_res, 32'h0);
      check("rst_done", 32'(div_done), 32'h0);
      check("rst_dbz", 32'(div_by_zero), 32'h0);
      check("rst_ovf", 32'(div_ovf), 32'h0);

      run_op("d100_7", 16'd100, 16'd7, 32'h0002_000E, 1'b0, 1'b0, 32'h0, 0, 0, 0);
      run_op("d1234_0", 16'd1234, 16'd0, 32'h04D2_FFFF, 1'b1, 1'b0, 32'h0002_000E, 0, 0, 0);
`ifdef DIV_SIGNED_EN
      run_op("neg100_7", 16'hFF9C, 16'd7, 32'hFFFE_FFF2, 1'b0, 1'b0, 32'h04D2_FFFF, 0, 0, 0);
      run_op("d100_neg7", 16'd100, 16'hFFF9, 32'h0002_FFF2, 1'b0, 1'b0, 32'hFFFE_FFF2, 0, 0, 0);
      run_op("ovf", 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b0, 1'b1, 32'h0002_FFF2, 0, 0, 0);
      run_op("pulses", 16'd200, 16'd9, 32'h0002_0016, 1'b0, 1'b0, 32'h0000_8000, 3, 17, 18);
`else
      run_op("uFF9C_7", 16'hFF9C, 16'd7, 32'h0000_2484, 1'b0, 1'b0, 32'h04D2_FFFF, 0, 0, 0);
      run_op("u8000_FFFF", 16'h8000, 16'hFFFF, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_2484, 0, 0, 0);
      run_op("pulses", 16'd200, 16'd9, 32'h0002_0016, 1'b0, 1'b0, 32'h8000_0000, 3, 17, 18);
`endif

      // Reset sampled in CALC cycle 8 abandons the op.
      src1        = 16'd100;
      src2        = 16'd7;
      parser_done = 1'b1;
      @(posedge clk);
      #1;
      parser_done = 1'b0;
      nd = 0;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk);
         #1;
         if (div_done === 1'b1) nd++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_res", calc_res, 32'h0);
      check("midrst_done", 32'(div_done), 32'h0);
      check("midrst_dbz", 32'(div_by_zero), 32'h0);
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (div_done === 1'b1) nd++;
      end
      check("midrst_nodone", 32'(nd), 32'h0);
      check("midrst_idle_res", calc_res, 32'h0);

      run_op("d9_3", 16'd9, 16'd3, 32'h0000_0003, 1'b0, 1'b0, 32'h0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
